// File: rtl/pad_input_filter_if.sv
// rtl/pad_input_filter_if.sv - control and status bundle for the pad input filter
interface pad_input_filter_if #(
  parameter int CNT_W = 8
);
  logic             pad_in_i;
  logic             en_i;
  logic             inv_i;
  logic [CNT_W-1:0] filt_cnt_i;
  logic [1:0]       edge_sel_i;
  logic             level_o;
  logic             rise_o;
  logic             fall_o;
  logic             event_o;
  logic             busy_o;

  modport master (
    output pad_in_i, en_i, inv_i, filt_cnt_i, edge_sel_i,
    input  level_o, rise_o, fall_o, event_o, busy_o
  );

  modport slave (
    input  pad_in_i, en_i, inv_i, filt_cnt_i, edge_sel_i,
    output level_o, rise_o, fall_o, event_o, busy_o
  );
endinterface

// File: rtl/pad_input_filter.sv
// rtl/pad_input_filter.sv - synchronise, invert and debounce a raw pad level into a clean level with edge pulses
module pad_input_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pad_input_filter_if.slave io
);

  typedef enum logic {IDLE, QUAL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  logic                   s;
  logic [CNT_W-1:0]       neff;
  logic [CNT_W:0]         cnt_p1;
  logic [CNT_W-1:0]       cnt_sat;
  logic                   qualified;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io.pad_in_i};
    end
  end

  assign s    = sync_q[SYNC_STAGES-1] ^ io.inv_i;
  assign neff = (io.filt_cnt_i == '0) ? CNT_ONE : io.filt_cnt_i;

  // Compare cnt+1 one bit wider so the check stays exact at the counter maximum.
  assign cnt_p1    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign qualified = (cnt_p1 >= {1'b0, neff});
  assign cnt_sat   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_p1[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.en_i && (s != level_q)) begin
          if (neff == CNT_ONE) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
          end else begin
            state_d = QUAL;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QUAL: begin
        if (!io.en_i || (s == level_q)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (qualified) begin
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign io.level_o = level_q;
  assign io.rise_o  = rise_q;
  assign io.fall_o  = fall_q;
  assign io.event_o = (rise_q & io.edge_sel_i[0]) | (fall_q & io.edge_sel_i[1]);
  assign io.busy_o  = (state_q == QUAL);

endmodule

// File: tb/tb_pad_input_filter.sv
// tb/tb_pad_input_filter.sv - directed self-checking bench for pad_input_filter
module tb_pad_input_filter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pad_input_filter_if #(.CNT_W(8)) f();

  pad_input_filter #(
    .SYNC_STAGES(2),
    .CNT_W(8),
    .RESET_VAL(1'b0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .io    (f.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({f.level_o, f.rise_o, f.fall_o, f.event_o, f.busy_o} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {f.level_o, f.rise_o, f.fall_o, f.event_o, f.busy_o});
    end
    rst_n = 1'b1;
    f.filt_cnt_i = 8'd3;
    f.pad_in_i = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (f.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_busy: got %b want 1", f.busy_o);
    end
    #2;
    f.pad_in_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({f.level_o, f.rise_o, f.fall_o, f.event_o, f.busy_o} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 00000", {f.level_o, f.rise_o, f.fall_o, f.event_o, f.busy_o});
    end
    repeat (4) begin
      tick();
      f.pad_in_i = ~f.pad_in_i;
    end
    n_checks++;
    if ({f.level_o, f.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_held: got %b want 00", {f.level_o, f.busy_o});
    end
    rst_n = 1'b1;
    f.pad_in_i = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({f.level_o, f.busy_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release_e4: got %b want 01", {f.level_o, f.busy_o});
    end
    tick();
    n_checks++;
    if ({f.level_o, f.rise_o, f.event_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_e5: got %b want 111", {f.level_o, f.rise_o, f.event_o});
    end
  endtask

  task automatic test_bypass();
    f.filt_cnt_i = 8'd0;
    f.edge_sel_i = 2'b01;
    f.pad_in_i = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (f.level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_start: got %b want 0", f.level_o);
    end
    f.pad_in_i = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({f.level_o, f.rise_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL bypass_e2: got %b want 00", {f.level_o, f.rise_o});
    end
    tick();
    n_checks++;
    if ({f.level_o, f.rise_o, f.fall_o, f.event_o} !== 4'b1101) begin
      n_fail++;
      $display("FAIL bypass_e3: got %b want 1101", {f.level_o, f.rise_o, f.fall_o, f.event_o});
    end
    tick();
    n_checks++;
    if ({f.level_o, f.rise_o, f.fall_o, f.event_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL bypass_e4: got %b want 1000", {f.level_o, f.rise_o, f.fall_o, f.event_o});
    end
    f.pad_in_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({f.level_o, f.rise_o, f.fall_o, f.event_o} !== 4'b0010) begin
      n_fail++;
      $display("FAIL bypass_fall: got %b want 0010", {f.level_o, f.rise_o, f.fall_o, f.event_o});
    end
    repeat (2) tick();
  endtask

  task automatic test_debounce();
    int busy_cnt;
    int rise_cnt;
    logic level_any;
    busy_cnt = 0;
    rise_cnt = 0;
    level_any = 1'b0;
    f.filt_cnt_i = 8'd5;
    f.pad_in_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) f.pad_in_i = 1'b0;
      busy_cnt += int'(f.busy_o);
      rise_cnt += int'(f.rise_o);
      level_any |= f.level_o;
    end
    n_checks++;
    if (busy_cnt != 4) begin
      n_fail++;
      $display("FAIL debounce_busy_cycles: got %0d want 4", busy_cnt);
    end
    n_checks++;
    if ({level_any, rise_cnt[0]} !== 2'b00 || rise_cnt != 0) begin
      n_fail++;
      $display("FAIL debounce_glitch: got level %b rises %0d want 0 0", level_any, rise_cnt);
    end
    rise_cnt = 0;
    f.pad_in_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      rise_cnt += int'(f.rise_o);
      if (i == 6) begin
        n_checks++;
        if ({f.level_o, f.busy_o} !== 2'b01) begin
          n_fail++;
          $display("FAIL debounce_e6: got %b want 01", {f.level_o, f.busy_o});
        end
      end
      if (i == 7) begin
        n_checks++;
        if ({f.level_o, f.rise_o, f.busy_o} !== 3'b110) begin
          n_fail++;
          $display("FAIL debounce_e7: got %b want 110", {f.level_o, f.rise_o, f.busy_o});
        end
      end
    end
    n_checks++;
    if (rise_cnt != 1) begin
      n_fail++;
      $display("FAIL debounce_rise_count: got %0d want 1", rise_cnt);
    end
  endtask

  task automatic test_edge_sel();
    logic [1:0] sel_t [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic       pad_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] exp_t [5] = '{3'b010, 3'b100, 3'b011, 3'b101, 3'b011};
    f.filt_cnt_i = 8'd2;
    for (int i = 0; i < 5; i++) begin
      f.edge_sel_i = sel_t[i];
      f.pad_in_i = pad_t[i];
      repeat (3) tick();
      n_checks++;
      if (f.level_o !== ~pad_t[i]) begin
        n_fail++;
        $display("FAIL edge_sel_early[%0d]: got %b want %b", i, f.level_o, ~pad_t[i]);
      end
      tick();
      n_checks++;
      if ({f.level_o, f.rise_o, f.fall_o, f.event_o} !== {pad_t[i], exp_t[i]}) begin
        n_fail++;
        $display("FAIL edge_sel[%0d]: got %b want %b", i, {f.level_o, f.rise_o, f.fall_o, f.event_o}, {pad_t[i], exp_t[i]});
      end
      repeat (2) tick();
    end
  endtask

  task automatic test_enable_invert();
    int pulses;
    logic busy_any;
    logic level_any;
    pulses = 0;
    busy_any = 1'b0;
    level_any = 1'b0;
    f.filt_cnt_i = 8'd2;
    f.en_i = 1'b0;
    f.pad_in_i = 1'b1;
    repeat (8) begin
      tick();
      pulses += int'(f.rise_o | f.fall_o);
      busy_any |= f.busy_o;
      level_any |= f.level_o;
    end
    n_checks++;
    if (pulses != 0 || {level_any, busy_any} !== 2'b00) begin
      n_fail++;
      $display("FAIL enable_frozen: got pulses %0d level %b busy %b want 0 0 0", pulses, level_any, busy_any);
    end
    f.en_i = 1'b1;
    tick();
    n_checks++;
    if ({f.level_o, f.busy_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL enable_qual: got %b want 01", {f.level_o, f.busy_o});
    end
    tick();
    n_checks++;
    if ({f.level_o, f.rise_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL enable_rise: got %b want 11", {f.level_o, f.rise_o});
    end
    repeat (2) tick();
    f.inv_i = 1'b1;
    tick();
    n_checks++;
    if ({f.level_o, f.busy_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL invert_qual: got %b want 11", {f.level_o, f.busy_o});
    end
    tick();
    n_checks++;
    if ({f.level_o, f.fall_o, f.event_o} !== 3'b011) begin
      n_fail++;
      $display("FAIL invert_fall: got %b want 011", {f.level_o, f.fall_o, f.event_o});
    end
    pulses = 0;
    level_any = 1'b0;
    repeat (5) begin
      tick();
      pulses += int'(f.rise_o | f.fall_o);
      level_any |= f.level_o;
    end
    n_checks++;
    if (pulses != 0 || level_any !== 1'b0) begin
      n_fail++;
      $display("FAIL invert_single: got pulses %0d level %b want 0 0", pulses, level_any);
    end
  endtask

  task automatic test_live_threshold();
    int   fall_at;
    int   busy_cnt;
    logic level_pre;
    rst_n = 1'b0;
    f.inv_i = 1'b0;
    f.pad_in_i = 1'b0;
    tick();
    rst_n = 1'b1;
    f.filt_cnt_i = 8'd10;
    tick();
    f.pad_in_i = 1'b1;
    repeat (8) tick();
    n_checks++;
    if ({f.level_o, f.busy_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL live_cnt6: got %b want 01", {f.level_o, f.busy_o});
    end
    f.filt_cnt_i = 8'd4;
    tick();
    n_checks++;
    if ({f.level_o, f.rise_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL live_reduce: got %b want 11", {f.level_o, f.rise_o});
    end
    repeat (3) tick();
    fall_at = 0;
    busy_cnt = 0;
    level_pre = 1'b0;
    f.filt_cnt_i = 8'd255;
    f.pad_in_i = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      busy_cnt += int'(f.busy_o);
      if (f.fall_o && fall_at == 0) fall_at = i;
      if (i == 256) level_pre = f.level_o;
    end
    n_checks++;
    if (fall_at != 257) begin
      n_fail++;
      $display("FAIL live_max_latency: got %0d want 257", fall_at);
    end
    n_checks++;
    if (busy_cnt != 254) begin
      n_fail++;
      $display("FAIL live_max_busy: got %0d want 254", busy_cnt);
    end
    n_checks++;
    if ({level_pre, f.level_o, f.busy_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL live_max_level: got %b want 100", {level_pre, f.level_o, f.busy_o});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    f.pad_in_i = 1'b0;
    f.en_i = 1'b1;
    f.inv_i = 1'b0;
    f.filt_cnt_i = 8'd3;
    f.edge_sel_i = 2'b01;
    test_reset();
    test_bypass();
    test_debounce();
    test_edge_sel();
    test_enable_invert();
    test_live_threshold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
